// File: rtl/uo_stream_arbiter.sv
// uo_stream_arbiter
//   Shares the 8-bit uo_out byte bus between several byte-stream sources
//   (0 = greeting, 1 = register readout, 2 = adventure engine). One source is
//   granted per message, round-robin, and keeps the grant until the byte marked
//   last. Each byte is held on the pins for HOLD enabled cycles so slow
//   off-chip observers can sample it.
//
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   ena        design enable; low freezes all state
//   src_valid  per-source byte available
//   src_data   per-source byte at [8*i+:8]
//   src_last   per-source byte is the final byte of its message
//   src_ready  combinational accept; transfer on valid & ready
//   out_data   byte presented on the pins
//   out_valid  out_data holds a live byte
//   out_last   presented byte ends its message
//   out_src    granted source index (held after the message ends)
//   busy       a message is in progress
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | no message; next cycle with a request picks a winner
//   SEND   | granted byte on the pins, hold counter running
//   STALL  | mid-message, granted source had no byte; grant stays locked
module uo_stream_arbiter #(
    parameter int NREQ = 3,
    parameter int HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NREQ-1:0]   src_valid,
    input  logic [8*NREQ-1:0] src_data,
    input  logic [NREQ-1:0]   src_last,
    output logic [NREQ-1:0]   src_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [1:0]        out_src,
    output logic              busy
);

    localparam int              HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HCW-1:0]  HOLD_TC   = HCW'(HOLD - 1);
    localparam logic [1:0]      LAST_INIT = 2'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_STALL} state_t;

    state_t         state_q, state_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]     last_grant_q, last_grant_d;
    logic [1:0]     out_src_q, out_src_d;
    logic [7:0]     out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
    logic           busy_q, busy_d;

    logic           win_found;
    logic [1:0]     win_idx;
    logic [1:0]     grant;
    logic           sel_valid;
    logic           sel_last;
    logic [7:0]     sel_data;
    logic           load;
    int             cand;

    // Round-robin search starting just after the previous message's owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant_q) + k) % NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!win_found && i == cand && src_valid[i]) begin
                    win_found = 1'b1;
                    win_idx   = 2'(i);
                end
            end
        end
    end

    // In IDLE the candidate is the fresh winner; otherwise the locked grant.
    always_comb begin
        grant     = (state_q == S_IDLE) ? win_idx : out_src_q;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (2'(i) == grant) begin
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
                sel_data  = src_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        last_grant_d = last_grant_q;
        out_src_d    = out_src_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        load         = 1'b0;

        // No transfer may happen in a reset cycle: the byte would be lost.
        if (ena && !rst) begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        out_src_d = win_idx;
                        load      = 1'b1;
                        state_d   = S_SEND;
                    end
                end
                S_SEND: begin
                    if (hold_cnt_q == HOLD_TC) begin
                        if (out_last_q) begin
                            last_grant_d = out_src_q;
                            out_valid_d  = 1'b0;
                            out_last_d   = 1'b0;
                            hold_cnt_d   = '0;
                            state_d      = S_IDLE;
                        end else if (sel_valid) begin
                            load = 1'b1;
                        end else begin
                            out_valid_d = 1'b0;
                            hold_cnt_d  = '0;
                            state_d     = S_STALL;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + HCW'(1);
                    end
                end
                S_STALL: begin
                    if (sel_valid) begin
                        load    = 1'b1;
                        state_d = S_SEND;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (load) begin
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_valid_d = 1'b1;
            hold_cnt_d  = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        src_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            src_ready[i] = load && (2'(i) == grant);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            last_grant_q <= LAST_INIT;
            out_src_q    <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_grant_q <= last_grant_d;
            out_src_q    <= out_src_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uo_stream_arbiter.sv
module tb_uo_stream_arbiter;

    localparam int HOLD_A = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ena_a;
    logic [2:0]  a_valid, a_last, a_ready;
    logic [23:0] a_data;
    logic [7:0]  a_odata;
    logic        a_ovalid, a_olast, a_busy;
    logic [1:0]  a_osrc;

    logic [2:0]  b_valid, b_last, b_ready;
    logic [23:0] b_data;
    logic [7:0]  b_odata;
    logic        b_ovalid, b_olast, b_busy;
    logic [1:0]  b_osrc;

    uo_stream_arbiter #(.NREQ(3), .HOLD(HOLD_A)) u_a (
        .clk(clk), .rst(rst), .ena(ena_a),
        .src_valid(a_valid), .src_data(a_data), .src_last(a_last), .src_ready(a_ready),
        .out_data(a_odata), .out_valid(a_ovalid), .out_last(a_olast),
        .out_src(a_osrc), .busy(a_busy)
    );

    uo_stream_arbiter #(.NREQ(3), .HOLD(1)) u_b (
        .clk(clk), .rst(rst), .ena(1'b1),
        .src_valid(b_valid), .src_data(b_data), .src_last(b_last), .src_ready(b_ready),
        .out_data(b_odata), .out_valid(b_ovalid), .out_last(b_olast),
        .out_src(b_osrc), .busy(b_busy)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Source models (entries {last, data}) and expected output scoreboards
    // (entries {src, last, data}).
    logic [8:0]  a_q0[$], a_q1[$], a_q2[$];
    logic [10:0] a_exp[$];
    logic [10:0] b_exp[$];
    int a_gap_cnt[3], a_gap_after[3], a_xcnt[3];

    logic       snap_ovalid, snap_olast, snap_busy;
    logic [7:0] snap_odata;
    logic [1:0] snap_osrc;
    logic [2:0] snap_ready;
    int a_vcyc, a_stall_cyc, a_r2_early;

    task automatic src_add(input int s, input logic l, input logic [7:0] d);
        case (s)
            0: a_q0.push_back({l, d});
            1: a_q1.push_back({l, d});
            default: a_q2.push_back({l, d});
        endcase
    endtask

    task automatic exp_add(input int s, input logic l, input logic [7:0] d);
        a_exp.push_back({2'(s), l, d});
    endtask

    task automatic a_present();
        logic [8:0] h;
        logic       have;
        a_valid = '0;
        a_data  = '0;
        a_last  = '0;
        for (int i = 0; i < 3; i++) begin
            h = '0;
            case (i)
                0: begin have = a_q0.size() > 0; if (have) h = a_q0[0]; end
                1: begin have = a_q1.size() > 0; if (have) h = a_q1[0]; end
                default: begin have = a_q2.size() > 0; if (have) h = a_q2[0]; end
            endcase
            if (a_gap_cnt[i] > 0) begin
                a_gap_cnt[i]--;
            end else if (have) begin
                a_valid[i]       = 1'b1;
                a_last[i]        = h[8];
                a_data[8*i +: 8] = h[7:0];
            end
        end
    endtask

    task automatic a_step();
        logic [2:0] xf;
        @(negedge clk);
        xf          = a_valid & a_ready;
        snap_ovalid = a_ovalid;
        snap_olast  = a_olast;
        snap_busy   = a_busy;
        snap_odata  = a_odata;
        snap_osrc   = a_osrc;
        snap_ready  = a_ready;
        if (a_ovalid) a_vcyc++;
        if (a_busy && !a_ovalid) a_stall_cyc++;
        if (a_ready[2] && a_q1.size() > 0) a_r2_early++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (xf[i]) begin
                case (i)
                    0: void'(a_q0.pop_front());
                    1: void'(a_q1.pop_front());
                    default: void'(a_q2.pop_front());
                endcase
                a_xcnt[i]++;
                if (a_xcnt[i] == a_gap_after[i]) a_gap_cnt[i] = 5;
            end
        end
        a_present();
    endtask

    task automatic do_reset();
        a_q0.delete(); a_q1.delete(); a_q2.delete(); a_exp.delete();
        for (int i = 0; i < 3; i++) begin
            a_gap_cnt[i] = 0; a_gap_after[i] = -1; a_xcnt[i] = 0;
        end
        rst = 1'b1;
        a_present();
        repeat (2) a_step();
        rst = 1'b0;
        a_vcyc = 0; a_stall_cyc = 0; a_r2_early = 0;
    endtask

    task automatic a_drain(input string name);
        int n = 0;
        while ((a_exp.size() > 0 || a_busy ||
                (a_q0.size() + a_q1.size() + a_q2.size()) > 0) && n < 400) begin
            a_step();
            n++;
        end
        check({name, "_timeout"}, int'(n < 400), 1);
    endtask

    // Monitor for DUT A: a byte is complete after HOLD enabled valid cycles.
    int          a_cnt = 0;
    logic [10:0] a_cur;
    logic        a_need_gap = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            a_cnt      = 0;
            a_need_gap = 1'b0;
        end else begin
            if (a_need_gap) begin
                check("a_idle_after_last", int'(a_ovalid), 0);
                a_need_gap = 1'b0;
            end
            if (a_ovalid) begin
                if (a_cnt == 0) a_cur = {a_osrc, a_olast, a_odata};
                else check("a_byte_stable", int'({a_osrc, a_olast, a_odata}), int'(a_cur));
                if (ena_a) a_cnt++;
                if (a_cnt == HOLD_A) begin
                    a_cnt = 0;
                    check("a_exp_available", int'(a_exp.size() > 0), 1);
                    if (a_exp.size() > 0) check("a_byte", int'(a_cur), int'(a_exp.pop_front()));
                    a_need_gap = a_cur[8];
                end
            end else begin
                if (a_cnt != 0) check("a_byte_len", a_cnt, HOLD_A);
                a_cnt = 0;
            end
        end
    end

    // Monitor for DUT B (HOLD=1): every valid cycle is one byte.
    int b_run = 0;
    int b_last_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            b_run = 0;
        end else if (b_ovalid) begin
            b_run++;
            check("b_exp_available", int'(b_exp.size() > 0), 1);
            if (b_exp.size() > 0) check("b_byte", int'({b_osrc, b_olast, b_odata}), int'(b_exp.pop_front()));
        end else begin
            if (b_run != 0) b_last_run = b_run;
            b_run = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic found;
        rst = 1'b1; ena_a = 1'b1;
        a_valid = '0; a_data = '0; a_last = '0;
        b_valid = '0; b_data = '0; b_last = '0;

        // Reset state
        do_reset();
        a_step();
        check("rst_out_valid", int'(snap_ovalid), 0);
        check("rst_out_last", int'(snap_olast), 0);
        check("rst_out_data", int'(snap_odata), 0);
        check("rst_out_src", int'(snap_osrc), 0);
        check("rst_busy", int'(snap_busy), 0);
        check("rst_ready", int'(snap_ready), 0);

        // 1: two-byte message from source 0
        do_reset();
        src_add(0, 1'b0, 8'h48); src_add(0, 1'b1, 8'h49);
        exp_add(0, 1'b0, 8'h48); exp_add(0, 1'b1, 8'h49);
        a_present();
        a_drain("t1");
        check("t1_valid_cycles", a_vcyc, 8);
        a_step();
        check("t1_end_valid", int'(snap_ovalid), 0);
        check("t1_end_busy", int'(snap_busy), 0);
        check("t1_end_src", int'(snap_osrc), 0);

        // 2: all sources requesting, two rounds
        do_reset();
        src_add(0, 1'b0, 8'h10); src_add(0, 1'b1, 8'h11);
        src_add(0, 1'b0, 8'h12); src_add(0, 1'b1, 8'h13);
        src_add(1, 1'b1, 8'h20);
        src_add(1, 1'b0, 8'h21); src_add(1, 1'b1, 8'h22);
        src_add(2, 1'b0, 8'h30); src_add(2, 1'b1, 8'h31);
        src_add(2, 1'b1, 8'h32);
        exp_add(0, 1'b0, 8'h10); exp_add(0, 1'b1, 8'h11);
        exp_add(1, 1'b1, 8'h20);
        exp_add(2, 1'b0, 8'h30); exp_add(2, 1'b1, 8'h31);
        exp_add(0, 1'b0, 8'h12); exp_add(0, 1'b1, 8'h13);
        exp_add(1, 1'b0, 8'h21); exp_add(1, 1'b1, 8'h22);
        exp_add(2, 1'b1, 8'h32);
        a_present();
        a_drain("t2");
        a_step();
        check("t2_src_held", int'(snap_osrc), 2);

        // 3: source 1 stalls after its first byte; source 2 must wait
        do_reset();
        a_gap_after[1] = 1;
        src_add(1, 1'b0, 8'h31); src_add(1, 1'b0, 8'h32); src_add(1, 1'b1, 8'h33);
        src_add(2, 1'b1, 8'h21);
        exp_add(1, 1'b0, 8'h31); exp_add(1, 1'b0, 8'h32); exp_add(1, 1'b1, 8'h33);
        exp_add(2, 1'b1, 8'h21);
        a_present();
        a_drain("t3");
        check("t3_stall_cycles", a_stall_cyc, 2);
        check("t3_src2_ready_early", a_r2_early, 0);
        check("t3_valid_cycles", a_vcyc, 16);

        // 4: enable low for three cycles in the middle of a byte
        do_reset();
        src_add(0, 1'b0, 8'h41); src_add(0, 1'b1, 8'h42);
        exp_add(0, 1'b0, 8'h41); exp_add(0, 1'b1, 8'h42);
        a_present();
        n = 0;
        do begin a_step(); n++; end while (!snap_ovalid && n < 20);
        check("t4_first_byte_seen", int'(snap_ovalid), 1);
        a_step();
        ena_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_step();
            check("t4_frozen_data", int'(snap_odata), 8'h41);
            check("t4_frozen_ready", int'(snap_ready), 0);
        end
        ena_a = 1'b1;
        a_drain("t4");
        check("t4_valid_cycles", a_vcyc, 11);

        // 5: reset while source 2's second byte is on the pins
        do_reset();
        src_add(2, 1'b0, 8'hB0); src_add(2, 1'b0, 8'hB1); src_add(2, 1'b1, 8'hB2);
        exp_add(2, 1'b0, 8'hB0);
        a_present();
        n = 0;
        found = 1'b0;
        while (!found && n < 60) begin
            a_step();
            n++;
            found = snap_ovalid && (snap_odata == 8'hB1);
        end
        check("t5_second_byte_seen", int'(found), 1);
        src_add(0, 1'b1, 8'h50);
        exp_add(0, 1'b1, 8'h50);
        exp_add(2, 1'b1, 8'hB2);
        rst = 1'b1;
        a_step();
        rst = 1'b0;
        a_step();
        check("t5_out_valid", int'(snap_ovalid), 0);
        check("t5_busy", int'(snap_busy), 0);
        check("t5_out_data", int'(snap_odata), 0);
        check("t5_winner_ready", int'(snap_ready), 3'b001);
        a_drain("t5");

        // 6: HOLD=1 instance, source 0 streams eight bytes
        for (int k = 0; k < 8; k++) b_exp.push_back({2'd0, 1'(k == 7), 8'(8'h60 + k)});
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            b_valid    = 3'b001;
            b_data     = {16'h0, 8'(8'h60 + k)};
            b_last     = {2'b00, 1'(k == 7)};
            @(negedge clk);
            check("t6_ready", int'(b_ready), 3'b001);
            @(posedge clk); #1;
        end
        b_valid = '0; b_data = '0; b_last = '0;
        repeat (4) @(posedge clk);
        #1;
        check("t6_run_length", b_last_run, 8);
        check("t6_exp_drained", b_exp.size(), 0);
        check("t5_exp_drained", a_exp.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
